// File: rtl/timing_gen.sv
// Machine-cycle beat generator: converts rising edges of the divided fen_clk
// into a four-beat T0..T3 sequence with run, halt and single-step control.
//
//   state | meaning
//   IDLE  | out of reset, no beats, waiting for start
//   RUN   | free-running machine cycles, one beat per fen_clk rising edge
//   STEP  | exactly one machine cycle, then back to HALT
//   HALT  | stopped on a machine-cycle boundary, waiting for start or step
module timing_gen (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        fen_clk,
    input  logic        start,
    input  logic        halt_req,
    input  logic        step,
    output logic [3:0]  t_phase,
    output logic        cycle_done,
    output logic [15:0] cycle_cnt,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic        done_q, done_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic        fen_dly_q;
    logic        halt_pend_q, halt_pend_d;
    logic        step_lock_q, step_lock_d;

    logic        tick;
    logic        running;
    logic        beat_end;

    assign tick     = fen_clk & ~fen_dly_q;
    assign running  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign beat_end = running && tick && phase_q[3];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A halt_req on the closing T3 tick itself still stops the machine there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_end && (halt_pend_q || halt_req)) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (beat_end) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else if (step && !step_lock_q) begin
                        state_d = ST_STEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        done_d      = 1'b0;
        cycle_cnt_d = cycle_cnt_q;
        halt_pend_d = halt_pend_q;
        step_lock_d = step_lock_q;

        if (running && tick) begin
            if (phase_q == 4'b0000) begin
                phase_d = 4'b0001;
            end else if (phase_q[3]) begin
                done_d      = 1'b1;
                cycle_cnt_d = cycle_cnt_q + 16'd1;
                phase_d     = (state_d == ST_HALT) ? 4'b0000 : 4'b0001;
            end else begin
                phase_d = {phase_q[2:0], 1'b0};
            end
        end

        if ((state_q == ST_RUN) && halt_req) begin
            halt_pend_d = 1'b1;
        end
        if ((state_q == ST_RUN) && (state_d == ST_HALT)) begin
            halt_pend_d = 1'b0;
        end

        // step must be seen low at least once after each completed step
        if (!step) begin
            step_lock_d = 1'b0;
        end
        if ((state_q == ST_STEP) && (state_d == ST_HALT)) begin
            step_lock_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase_q     <= 4'b0000;
            done_q      <= 1'b0;
            cycle_cnt_q <= 16'd0;
            fen_dly_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            step_lock_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
            fen_dly_q   <= fen_clk;
            halt_pend_q <= halt_pend_d;
            step_lock_q <= step_lock_d;
        end
    end

    always_comb begin
        t_phase    = phase_q;
        cycle_done = done_q;
        cycle_cnt  = cycle_cnt_q;
        state_o    = state_q;
    end

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: run, halt, single step, fen_clk stall,
// counter wrap and mid-cycle reset with hand-computed expectations.
module tb_timing_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        fen_clk;
    logic        start;
    logic        halt_req;
    logic        step;
    logic [3:0]  t_phase;
    logic        cycle_done;
    logic [15:0] cycle_cnt;
    logic [1:0]  state_o;

    int   n_checks = 0;
    int   n_errors = 0;
    logic fen_on;
    int   div;
    int   pulses;
    int   guard;

    always #5 sys_clk = ~sys_clk;

    timing_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .fen_clk    (fen_clk),
        .start      (start),
        .halt_req   (halt_req),
        .step       (step),
        .t_phase    (t_phase),
        .cycle_done (cycle_done),
        .cycle_cnt  (cycle_cnt),
        .state_o    (state_o)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n sys_clk edges; the divider model sets fen_clk for the next edge.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            if (fen_on) begin
                div     = (div + 1) % 4;
                fen_clk = (div < 2);
            end
        end
    endtask

    task automatic adv_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            adv(1);
            if (cycle_done) cnt++;
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        step     = 1'b0;
        fen_on   = 1'b0;
        div      = 3;
        fen_clk  = 1'b0;
        adv(3);
        check_val("rst_state", 16'(state_o), 16'h0);
        check_val("rst_phase", 16'(t_phase), 16'h0);
        check_val("rst_cnt", cycle_cnt, 16'h0);
        check_val("rst_done", 16'(cycle_done), 16'h0);

        // divider-rate run, three machine cycles
        sys_rst = 1'b0;
        start   = 1'b1;
        fen_on  = 1'b1;
        adv(1);
        check_val("enter_run_state", 16'(state_o), 16'h1);
        check_val("enter_run_phase", 16'(t_phase), 16'h0);
        for (int j = 0; j < 49; j++) begin
            logic [3:0] ep;
            adv(1);
            ep = 4'b0001 << ((j / 4) % 4);
            check_val("run_phase", 16'(t_phase), 16'(ep));
            check_val("run_done", 16'(cycle_done), 16'((j % 16 == 0) && (j > 0)));
        end
        check_val("run_cnt3", cycle_cnt, 16'd3);

        // halt_req pulsed during T1
        adv(5);
        check_val("halt_t1_phase", 16'(t_phase), 16'h2);
        halt_req = 1'b1;
        start    = 1'b0;
        adv(1);
        halt_req = 1'b0;
        check_val("halt_pulse_phase", 16'(t_phase), 16'h2);
        adv_count(9, pulses);
        check_val("halt_pre_pulses", 16'(pulses), 16'd0);
        check_val("halt_t3_phase", 16'(t_phase), 16'h8);
        adv(1);
        check_val("halt_done", 16'(cycle_done), 16'h1);
        check_val("halt_cnt", cycle_cnt, 16'd4);
        check_val("halt_state", 16'(state_o), 16'h3);
        check_val("halt_phase", 16'(t_phase), 16'h0);
        adv_count(16, pulses);
        check_val("halt_idle_pulses", 16'(pulses), 16'd0);
        check_val("halt_frozen_cnt", cycle_cnt, 16'd4);
        check_val("halt_hold_phase", 16'(t_phase), 16'h0);

        // single step held high
        step = 1'b1;
        adv(1);
        check_val("step_state", 16'(state_o), 16'h2);
        check_val("step_phase0", 16'(t_phase), 16'h0);
        adv(3);
        check_val("step_t0", 16'(t_phase), 16'h1);
        adv(12);
        check_val("step_t3", 16'(t_phase), 16'h8);
        check_val("step_t3_state", 16'(state_o), 16'h2);
        adv(4);
        check_val("step_done", 16'(cycle_done), 16'h1);
        check_val("step_cnt", cycle_cnt, 16'd5);
        check_val("step_back_halt", 16'(state_o), 16'h3);
        check_val("step_end_phase", 16'(t_phase), 16'h0);
        adv_count(21, pulses);
        check_val("step_held_pulses", 16'(pulses), 16'd0);
        check_val("step_held_state", 16'(state_o), 16'h3);
        check_val("step_held_cnt", cycle_cnt, 16'd5);

        step = 1'b0;
        adv(1);
        step = 1'b1;
        adv(1);
        check_val("step2_state", 16'(state_o), 16'h2);
        adv(17);
        check_val("step2_done", 16'(cycle_done), 16'h1);
        check_val("step2_cnt", cycle_cnt, 16'd6);
        check_val("step2_halt", 16'(state_o), 16'h3);
        adv_count(12, pulses);
        check_val("step2_held_pulses", 16'(pulses), 16'd0);
        check_val("step2_held_cnt", cycle_cnt, 16'd6);

        // halt_req blocks start and step; then start wins over step
        step = 1'b0;
        adv(1);
        step     = 1'b1;
        start    = 1'b1;
        halt_req = 1'b1;
        adv(3);
        check_val("halt_blocks_state", 16'(state_o), 16'h3);
        check_val("halt_blocks_phase", 16'(t_phase), 16'h0);
        halt_req = 1'b0;
        adv(1);
        check_val("start_priority", 16'(state_o), 16'h1);
        start = 1'b0;
        step  = 1'b0;

        // fen_clk stalled low during T2
        adv(11);
        check_val("stall_t2", 16'(t_phase), 16'h4);
        adv(1);
        fen_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            check_val("stall_hold", 16'(t_phase), 16'h4);
        end
        div     = 0;
        fen_clk = 1'b1;
        fen_on  = 1'b1;
        adv(1);
        check_val("stall_resume_t3", 16'(t_phase), 16'h8);
        adv(4);
        check_val("stall_done", 16'(cycle_done), 16'h1);
        check_val("stall_cnt", cycle_cnt, 16'd7);
        check_val("stall_next_t0", 16'(t_phase), 16'h1);

        // halt_req on the same edge as the T3 tick
        adv(15);
        check_val("edge_halt_t3", 16'(t_phase), 16'h8);
        halt_req = 1'b1;
        adv(1);
        halt_req = 1'b0;
        check_val("edge_halt_done", 16'(cycle_done), 16'h1);
        check_val("edge_halt_cnt", cycle_cnt, 16'd8);
        check_val("edge_halt_state", 16'(state_o), 16'h3);
        check_val("edge_halt_phase", 16'(t_phase), 16'h0);
        adv_count(8, pulses);
        check_val("edge_halt_pulses", 16'(pulses), 16'd0);
        check_val("edge_halt_no_t0", 16'(t_phase), 16'h0);

        // reset during T2
        start = 1'b1;
        adv(1);
        check_val("rerun_state", 16'(state_o), 16'h1);
        start = 1'b0;
        adv(11);
        check_val("mid_rst_t2", 16'(t_phase), 16'h4);
        adv(1);
        sys_rst = 1'b1;
        adv(1);
        sys_rst = 1'b0;
        check_val("mid_rst_state", 16'(state_o), 16'h0);
        check_val("mid_rst_phase", 16'(t_phase), 16'h0);
        check_val("mid_rst_cnt", cycle_cnt, 16'h0);
        check_val("mid_rst_done", 16'(cycle_done), 16'h0);
        adv_count(12, pulses);
        check_val("mid_rst_pulses", 16'(pulses), 16'd0);
        check_val("mid_rst_idle", 16'(state_o), 16'h0);

        // start together with halt_req stays in IDLE
        halt_req = 1'b1;
        start    = 1'b1;
        adv(1);
        check_val("idle_start_halt", 16'(state_o), 16'h0);
        adv(2);
        check_val("idle_start_halt2", 16'(state_o), 16'h0);
        halt_req = 1'b0;
        start    = 1'b0;

        force dut.cycle_cnt_q = 16'hFFFE;
        adv(1);
        release dut.cycle_cnt_q;
        check_val("preload_cnt", cycle_cnt, 16'hFFFE);

        // start on a tick edge: first beat waits for the following tick
        guard = 0;
        while ((div != 0) && (guard < 8)) begin
            adv(1);
            guard++;
        end
        check_val("tick_sync", 16'(div == 0), 16'h1);
        start = 1'b1;
        adv(1);
        start = 1'b0;
        check_val("tick_start_state", 16'(state_o), 16'h1);
        check_val("tick_start_phase", 16'(t_phase), 16'h0);
        adv(3);
        check_val("tick_start_wait", 16'(t_phase), 16'h0);
        adv(1);
        check_val("tick_start_t0", 16'(t_phase), 16'h1);
        adv(16);
        check_val("wrap_ffff_done", 16'(cycle_done), 16'h1);
        check_val("wrap_ffff_cnt", cycle_cnt, 16'hFFFF);
        adv(16);
        check_val("wrap_zero_done", 16'(cycle_done), 16'h1);
        check_val("wrap_zero_cnt", cycle_cnt, 16'h0000);
        check_val("wrap_state", 16'(state_o), 16'h1);
        adv(1);
        check_val("wrap_done_pulse_len", 16'(cycle_done), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 The block SHALL have port sys_clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port fen_clk, input, 1 bit: divided clock from the clock-divider stage, synchronous to sys_clk, nominal period 4 sys_clk with 2 high.
REQ-004 The block SHALL have port start, input, 1 bit: level, sampled each sys_clk; requests run from IDLE or HALT.
REQ-005 The block SHALL have port halt_req, input, 1 bit: level, sampled each sys_clk; requests stop at the next machine-cycle boundary.
REQ-006 The block SHALL have port step, input, 1 bit: level, sampled each sys_clk; in HALT, runs exactly one machine cycle.
REQ-007 The block SHALL have port t_phase, output, 4 bits: one-hot beat T0..T3 (bit0=T0); 0000 when not running.
REQ-008 The block SHALL have port cycle_done, output, 1 bit: one-sys_clk pulse at the end of each completed machine cycle.
REQ-009 The block SHALL have port cycle_cnt, output, 16 bits: count of completed machine cycles.
REQ-010 The block SHALL have port state_o, output, 2 bits: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.

Function
REQ-011 The block SHALL register fen_clk into fen_d each sys_clk; tick = fen_clk & ~fen_d (one sys_clk per fen_clk rising edge).
REQ-012 The block SHALL update t_phase, cycle_done, cycle_cnt and state only on edges where tick=1, except the start/step/halt transitions stated below.
REQ-013 The block SHALL NOT change t_phase when tick=0; a stalled fen_clk freezes the beat.
REQ-014 In IDLE with start=1 and halt_req=0, the block SHALL enter RUN on the next edge; t_phase stays 0000 until the first tick, which sets 0001.
REQ-015 In RUN, each tick SHALL rotate t_phase 0001->0010->0100->1000->0001.
REQ-016 On a tick with t_phase=1000, the block SHALL assert cycle_done for that following sys_clk and increment cycle_cnt by 1, wrapping 0xFFFF->0x0000.
REQ-017 The block SHALL set a halt_pend flag when halt_req=1 in RUN; the flag SHALL hold until consumed.
REQ-018 On a T3 tick with halt_pend=1, the block SHALL enter HALT, t_phase=0000, clear halt_pend; cycle_done and the cycle_cnt increment still occur.
REQ-019 In HALT: start=1 and step=1 SHALL NOT be honoured while halt_req=1.
REQ-020 In HALT, with halt_req=0: start=1 SHALL enter RUN (priority over step); step=1 alone SHALL enter STEP.
REQ-021 STEP SHALL behave as RUN for exactly one machine cycle (T0..T3), then return to HALT at the T3 tick.
REQ-022 step SHALL be level-qualified: after STEP completes, the block SHALL require step=0 for at least one sys_clk before another STEP.
REQ-023 In IDLE, start=1 with halt_req=1 on the same edge SHALL leave the block in IDLE.
REQ-024 halt_req arriving on the same edge as a T3 tick SHALL take effect at that boundary (HALT entered, no further T0).
REQ-025 A tick on the same edge as the IDLE->RUN transition SHALL NOT advance t_phase; the first beat uses the next tick.

Reset
REQ-026 When sys_rst=1 at a sys_clk edge, the block SHALL set state=IDLE, t_phase=0000, cycle_done=0, cycle_cnt=0, fen_d=0, halt_pend=0, and clear the step re-arm flag.
REQ-027 Reset mid-cycle SHALL abandon the beat with no cycle_done pulse; reset SHALL dominate all inputs.

Verification
REQ-028 Divider-rate fen_clk, start held 1 -> t_phase 0001 after first tick, each beat 4 sys_clk, cycle_done every 16 sys_clk, cycle_cnt=3 after 3 machine cycles.
REQ-029 RUN, halt_req pulsed 1 sys_clk during T1 -> T2, T3 complete, cycle_done=1 once, then HALT with t_phase=0000 and cycle_cnt frozen.
REQ-030 HALT, step held high 40 sys_clk -> exactly one T0..T3 sequence, cycle_cnt +1; step low 1 clk then high -> second sequence.
REQ-031 fen_clk held 0 for 20 sys_clk in T2 -> t_phase stays 0100; resumes at T3 on next rising edge.
REQ-032 cycle_cnt preloaded near wrap by running 65535 cycles, then one more -> cycle_cnt=0x0000, cycle_done pulses.
REQ-033 sys_rst=1 for one clk during T2 -> next cycle IDLE, t_phase=0000, cycle_cnt=0, no cycle_done.
